// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
//   Shared types and helpers for the baccarat round sequencer.
//   - deal_state_t : round sequencer state encoding
//   - CARD_*       : card code constants as produced by the dealer
//                    (0 empty, 1 ace, 2-10 pip cards, 11-13 J/Q/K)
//   - card_value() : maps a card code to its baccarat point value (0-9)
// -----------------------------------------------------------------------------
package baccarat_pkg;

    typedef enum logic [3:0] {
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        CHECK4,
        DEAL_P3,
        CHECK_B,
        DEAL_D3,
        RESULT,
        DONE
    } deal_state_t;

    localparam logic [3:0] CARD_EMPTY = 4'd0;
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

    // Tens and face cards count zero; an empty slot also counts zero.
    // Codes 14/15 never come out of the dealer and are folded to zero.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        if (code == CARD_EMPTY || code >= 4'd10) begin
            return 4'd0;
        end
        return code;
    endfunction

endpackage

// File: rtl/baccarat_banker_rule.sv
// -----------------------------------------------------------------------------
// baccarat_banker_rule
//   Combinational banker third-card decision, used once the player has drawn.
//   Ports:
//     dscore [3:0] in  banker two-card score, 0-9
//     pcard3 [3:0] in  player third-card code
//     draw         out 1 when the banker must take a third card
// -----------------------------------------------------------------------------
module baccarat_banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] v;

    always_comb begin
        v    = card_value(pcard3);
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_deal_ctrl.sv
// -----------------------------------------------------------------------------
// baccarat_deal_ctrl
//   Round sequencer for the baccarat table. Each step pulse in a DEAL_* state
//   produces one load strobe (Mealy, same cycle as step). After four cards the
//   natural / third-card rules run automatically from the fed-back scores, and
//   the win lights are latched in RESULT. A tie lights both.
//
//   Optional feature (compile macro BACCARAT_NEW_ROUND_EN):
//     defined   - step in DONE pulses clear_hand and starts a new round
//     undefined - DONE is terminal until resetb; clear_hand is tied low
//
//   Ports:
//     slow_clock  in   sole clock
//     resetb      in   asynchronous active-low reset
//     step        in   one-cycle advance pulse
//     pscore[3:0] in   player hand score (valid the cycle after a load)
//     dscore[3:0] in   banker hand score
//     pcard3[3:0] in   player third-card code
//     load_pcard1..3, load_dcard1..3  out  one-cycle card load strobes
//     clear_hand  out  one-cycle clear of all card registers
//     player_win_light, dealer_win_light  out  registered result lights
//     round_done  out  high while in DONE
// -----------------------------------------------------------------------------
module baccarat_deal_ctrl
    import baccarat_pkg::*;
#(
    parameter int unsigned NATURAL_MIN = 8,
    parameter int unsigned DRAW_LIMIT  = 5
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clear_hand,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       round_done
);

    localparam logic [3:0] NAT_MIN  = 4'(NATURAL_MIN);
    localparam logic [3:0] DRAW_LIM = 4'(DRAW_LIMIT);

    deal_state_t state_reg, state_next;
    logic        pwin_reg, pwin_next;
    logic        dwin_reg, dwin_next;
    logic        banker_draw;
    logic        new_round;

    baccarat_banker_rule u_banker_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

`ifdef BACCARAT_NEW_ROUND_EN
    assign new_round = (state_reg == DONE) && step;
`else
    assign new_round = 1'b0;
`endif

    assign clear_hand       = new_round;
    assign player_win_light = pwin_reg;
    assign dealer_win_light = dwin_reg;
    assign round_done       = (state_reg == DONE);

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_reg <= DEAL_P1;
            pwin_reg  <= 1'b0;
            dwin_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pwin_reg  <= pwin_next;
            dwin_reg  <= dwin_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pwin_next   = pwin_reg;
        dwin_next   = dwin_reg;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;

        case (state_reg)
            DEAL_P1: if (step) begin load_pcard1 = 1'b1; state_next = DEAL_D1; end
            DEAL_D1: if (step) begin load_dcard1 = 1'b1; state_next = DEAL_P2; end
            DEAL_P2: if (step) begin load_pcard2 = 1'b1; state_next = DEAL_D2; end
            DEAL_D2: if (step) begin load_dcard2 = 1'b1; state_next = CHECK4;  end

            CHECK4: begin
                if (pscore >= NAT_MIN || dscore >= NAT_MIN) begin
                    state_next = RESULT;
                end else if (pscore <= DRAW_LIM) begin
                    state_next = DEAL_P3;
                end else if (dscore <= DRAW_LIM) begin
                    // Player stood, so the banker follows the player's limit.
                    state_next = DEAL_D3;
                end else begin
                    state_next = RESULT;
                end
            end

            DEAL_P3: if (step) begin load_pcard3 = 1'b1; state_next = CHECK_B; end

            // pcard3 and dscore are stable here: the player card was loaded
            // on the edge that entered this state.
            CHECK_B: state_next = banker_draw ? DEAL_D3 : RESULT;

            DEAL_D3: if (step) begin load_dcard3 = 1'b1; state_next = RESULT; end

            RESULT: begin
                pwin_next  = (pscore >= dscore);
                dwin_next  = (dscore >= pscore);
                state_next = DONE;
            end

            DONE: begin
                if (new_round) begin
                    pwin_next  = 1'b0;
                    dwin_next  = 1'b0;
                    state_next = DEAL_P1;
                end
            end

            default: state_next = DEAL_P1;
        endcase
    end

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// -----------------------------------------------------------------------------
// tb_baccarat_deal_ctrl
//   Self-checking bench: a card/score datapath model feeds scores back to the
//   sequencer, and a rules-level baccarat model predicts the strobe sequence
//   and the final lights for directed and random hands.
// -----------------------------------------------------------------------------
module tb_baccarat_deal_ctrl;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic       step       = 1'b0;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       clear_hand, player_win_light, dealer_win_light, round_done;

    int checks = 0;
    int errors = 0;

    always #5 slow_clock = ~slow_clock;

    baccarat_deal_ctrl dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .step             (step),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .clear_hand       (clear_hand),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .round_done       (round_done)
    );

    // Stand-alone instance of the banker rule for an exhaustive sweep.
    logic [3:0] br_dscore, br_pcard3;
    logic       br_draw;
    baccarat_banker_rule u_rule (
        .dscore (br_dscore),
        .pcard3 (br_pcard3),
        .draw   (br_draw)
    );

    // ---------------- datapath model: card registers + scores ----------------
    logic [3:0] deck_p [3];   // cards the dealer will hand out next
    logic [3:0] deck_d [3];
    logic [3:0] hand_p [3];
    logic [3:0] hand_d [3];

    function automatic int val(input int code);
        return (code >= 10) ? 0 : code;
    endfunction

    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb || clear_hand) begin
            for (int i = 0; i < 3; i++) begin
                hand_p[i] <= 4'd0;
                hand_d[i] <= 4'd0;
            end
        end else begin
            if (load_pcard1) hand_p[0] <= deck_p[0];
            if (load_pcard2) hand_p[1] <= deck_p[1];
            if (load_pcard3) hand_p[2] <= deck_p[2];
            if (load_dcard1) hand_d[0] <= deck_d[0];
            if (load_dcard2) hand_d[1] <= deck_d[1];
            if (load_dcard3) hand_d[2] <= deck_d[2];
        end
    end

    assign pscore = 4'((val(hand_p[0]) + val(hand_p[1]) + val(hand_p[2])) % 10);
    assign dscore = 4'((val(hand_d[0]) + val(hand_d[1]) + val(hand_d[2])) % 10);
    assign pcard3 = hand_p[2];

    // ---------------- reference model ----------------
    // Strobe vector bit order: {p1,d1,p2,d2,p3,d3}
    localparam int S_P1 = 32, S_D1 = 16, S_P2 = 8, S_D2 = 4, S_P3 = 2, S_D3 = 1;

    function automatic bit banker_draws(input int ds, input int p3code);
        int v;
        v = val(p3code);
        if (ds <= 2) return 1'b1;
        if (ds == 3) return v != 8;
        if (ds == 4) return v inside {[2:7]};
        if (ds == 5) return v inside {[4:7]};
        if (ds == 6) return v inside {6, 7};
        return 1'b0;
    endfunction

    int exp_seq[$];
    int exp_pwin, exp_dwin;

    task automatic build_model();
        int ps, ds;
        exp_seq = '{S_P1, S_D1, S_P2, S_D2};
        ps = (val(deck_p[0]) + val(deck_p[1])) % 10;
        ds = (val(deck_d[0]) + val(deck_d[1])) % 10;
        if (ps < 8 && ds < 8) begin
            if (ps <= 5) begin
                exp_seq.push_back(S_P3);
                if (banker_draws(ds, deck_p[2])) begin
                    exp_seq.push_back(S_D3);
                    ds = (ds + val(deck_d[2])) % 10;
                end
                ps = (ps + val(deck_p[2])) % 10;
            end else if (ds <= 5) begin
                exp_seq.push_back(S_D3);
                ds = (ds + val(deck_d[2])) % 10;
            end
        end
        exp_pwin = (ps >= ds) ? 1 : 0;
        exp_dwin = (ds >= ps) ? 1 : 0;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int strobes();
        return {26'd0, load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                load_pcard3, load_dcard3};
    endfunction

    // One step pulse; returns the strobe vector and clear_hand seen mid-pulse.
    task automatic do_step(input int idle, output int vec, output int clr);
        @(posedge slow_clock); #1 step = 1'b1;
        @(negedge slow_clock);
        vec = strobes();
        clr = int'(clear_hand);
        @(posedge slow_clock); #1 step = 1'b0;
        repeat (idle) @(posedge slow_clock);
        #1;
    endtask

    task automatic set_deck(input int p1, d1, p2, d2, p3, d3);
        deck_p[0] = 4'(p1); deck_p[1] = 4'(p2); deck_p[2] = 4'(p3);
        deck_d[0] = 4'(d1); deck_d[1] = 4'(d2); deck_d[2] = 4'(d3);
    endtask

    task automatic do_reset();
        #2 resetb = 1'b0;
        #1;
        check("reset_round_done", int'(round_done), 0);
        check("reset_lights", int'({player_win_light, dealer_win_light}), 0);
        check("reset_strobes", strobes(), 0);
        @(negedge slow_clock); resetb = 1'b1;
    endtask

    // Play a full round with the deck already loaded and check every step.
    task automatic play_round(input string name);
        int vec, clr;
        build_model();
        foreach (exp_seq[i]) begin
            do_step(4, vec, clr);
            check({name, "_strobe"}, vec, exp_seq[i]);
        end
        check({name, "_done"}, int'(round_done), 1);
        check({name, "_pwin"}, int'(player_win_light), exp_pwin);
        check({name, "_dwin"}, int'(dealer_win_light), exp_dwin);
        $display("round %s cards P %0d %0d %0d D %0d %0d %0d strobes %0d lights %0d%0d",
                 name, deck_p[0], deck_p[1], deck_p[2], deck_d[0], deck_d[1],
                 deck_d[2], exp_seq.size(), player_win_light, dealer_win_light);
    endtask

    // Step in DONE, then leave the DUT ready for the next round.
    task automatic end_round(input string name);
        int vec, clr;
        do_step(1, vec, clr);
        check({name, "_donestep_strobe"}, vec, 0);
`ifdef BACCARAT_NEW_ROUND_EN
        check({name, "_clear_hand"}, clr, 1);
        check({name, "_new_done"}, int'(round_done), 0);
        check({name, "_new_lights"}, int'({player_win_light, dealer_win_light}), 0);
`else
        check({name, "_clear_hand"}, clr, 0);
        check({name, "_held_done"}, int'(round_done), 1);
        check({name, "_held_lights"}, int'({player_win_light, dealer_win_light}),
              exp_pwin * 2 + exp_dwin);
        do_reset();
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vec, clr;
        set_deck(0, 0, 0, 0, 0, 0);

        // Banker rule sweep against the rules table.
        for (int d = 0; d < 10; d++) begin
            for (int c = 0; c < 14; c++) begin
                br_dscore = 4'(d);
                br_pcard3 = 4'(c);
                #1;
                check($sformatf("rule_d%0d_c%0d", d, c), int'(br_draw),
                      int'(banker_draws(d, c)));
            end
        end

        // Reset state.
        #3;
        check("por_round_done", int'(round_done), 0);
        check("por_lights", int'({player_win_light, dealer_win_light}), 0);
        check("por_strobes", strobes(), 0);
        @(negedge slow_clock); resetb = 1'b1;
        repeat (2) @(posedge slow_clock);
        #1;
        check("idle_no_strobe", strobes(), 0);

        // Natural 9 vs 3: exact latency of round_done after the fourth step.
        set_deck(4, 1, 5, 2, 6, 6);
        build_model();
        for (int i = 0; i < 4; i++) begin
            do_step((i == 3) ? 0 : 2, vec, clr);
            check("nat_strobe", vec, exp_seq[i]);
        end
        check("nat_done_early", int'(round_done), 0);
        @(posedge slow_clock); #1;
        check("nat_done_1cyc", int'(round_done), 0);
        @(posedge slow_clock); #1;
        check("nat_done_2cyc", int'(round_done), 1);
        check("nat_pwin", int'(player_win_light), 1);
        check("nat_dwin", int'(dealer_win_light), 0);
        $display("round natural lights %0d%0d", player_win_light, dealer_win_light);
        end_round("nat");

        // Player draws a king, banker stands on 7.
        set_deck(2, 3, 2, 4, 13, 1);   play_round("p3_king");  end_round("p3_king");
        // Banker 6, player third 7 -> banker draws.
        set_deck(1, 3, 2, 3, 7, 2);    play_round("b6_p7");    end_round("b6_p7");
        // Banker 6, player third 5 -> banker stands.
        set_deck(1, 3, 2, 3, 5, 2);    play_round("b6_p5");    end_round("b6_p5");
        // Banker 3, player third 8 -> banker stands.
        set_deck(1, 1, 2, 2, 8, 4);    play_round("b3_p8");    end_round("b3_p8");
        // Player stands on 6, banker 5 draws an ace -> tie.
        set_deck(3, 2, 3, 3, 9, 1);    play_round("pstand");   end_round("pstand");

        // Reset in the middle of a deal.
        set_deck(1, 2, 3, 4, 5, 6);
        for (int i = 0; i < 3; i++) do_step(2, vec, clr);
        do_reset();
        do_step(2, vec, clr);
        check("post_reset_first", vec, S_P1);
        do_reset();

        // Random hands.
        for (int r = 0; r < 40; r++) begin
            set_deck($urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13),
                     $urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13));
            play_round($sformatf("rand%0d", r));
            end_round($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
